// File: rtl/traffic_pkg.sv
// Shared types for the highway/farm-road light sequencer: state and light encodings plus light decode.
// The AR state is only reachable when the design is built with ALL_RED_EN.
package traffic_pkg;

  typedef enum logic [2:0] {
    HG = 3'd0,
    HY = 3'd1,
    FG = 3'd2,
    FY = 3'd3,
    AR = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_e;

  typedef struct packed {
    light_e hwy;
    light_e farm;
  } lights_t;

  // Light pair shown while in a given state; anything unknown shows all red.
  function automatic lights_t decode_lights(state_e s);
    lights_t l;
    l.hwy  = RED;
    l.farm = RED;
    case (s)
      HG:      l.hwy  = GREEN;
      HY:      l.hwy  = YELLOW;
      FG:      l.farm = GREEN;
      FY:      l.farm = YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick down-counter: reloads on load, decrements on tick_en, saturates at zero.
// done marks a tick cycle on which the phase has no ticks left.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick_en,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (load) begin
      r_count <= load_val;
    end else if (tick_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign done = tick_en && (r_count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Highway/farm-road traffic-light Moore sequencer with tick-based per-phase timing.
// Define ALL_RED_EN to insert an all-red clearance phase (T_AR ticks) after each yellow.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_HG_MIN = 5,
  parameter int unsigned T_Y      = 1,
`ifdef ALL_RED_EN
  parameter int unsigned T_FG_MAX = 5,
  parameter int unsigned T_AR     = 1
`else
  parameter int unsigned T_FG_MAX = 5
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       car,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic       phase_start,
  output logic [2:0] state_o
);

  state_e           r_state;
  light_e           r_hwy;
  light_e           r_farm;
  logic             r_phase_start;
`ifdef ALL_RED_EN
  logic             r_from_fy;
`endif
  state_e           w_next;
  logic             w_done;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  lights_t          w_lights;

  // Timer reload value for a state: the phase spans exactly that many ticks.
  function automatic logic [CNT_W-1:0] dur_of(state_e s);
    logic [CNT_W-1:0] d;
    d = CNT_W'(T_HG_MIN - 1);
    case (s)
      HY, FY:  d = CNT_W'(T_Y - 1);
      FG:      d = CNT_W'(T_FG_MAX - 1);
`ifdef ALL_RED_EN
      AR:      d = CNT_W'(T_AR - 1);
`endif
      default: ;
    endcase
    return d;
  endfunction

  // Next-state decision; all transitions wait for a tick cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      HG: if (w_done && car) w_next = HY;
`ifdef ALL_RED_EN
      HY: if (w_done) w_next = AR;
      FG: if (w_done || (tick_en && !car)) w_next = FY;
      FY: if (w_done) w_next = AR;
      AR: if (w_done) w_next = r_from_fy ? HG : FG;
`else
      HY: if (w_done) w_next = FG;
      FG: if (w_done || (tick_en && !car)) w_next = FY;
      FY: if (w_done) w_next = HG;
`endif
      default: w_next = HG;
    endcase
  end

  // Reset and every state change reload the timer for the phase being entered.
  assign w_load     = !rst_n || (w_next != r_state);
  assign w_load_val = rst_n ? dur_of(w_next) : dur_of(HG);
  assign w_lights   = decode_lights(w_next);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .load     (w_load),
    .load_val (w_load_val),
    .tick_en  (tick_en),
    .done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= HG;
      r_hwy         <= GREEN;
      r_farm        <= RED;
      r_phase_start <= 1'b0;
`ifdef ALL_RED_EN
      r_from_fy     <= 1'b0;
`endif
    end else begin
      r_state       <= w_next;
      r_hwy         <= w_lights.hwy;
      r_farm        <= w_lights.farm;
      r_phase_start <= (w_next != r_state);
`ifdef ALL_RED_EN
      if ((w_next == AR) && (r_state != AR)) begin
        r_from_fy <= (r_state == FY);
      end
`endif
    end
  end

  assign hwy_light   = r_hwy;
  assign farm_light  = r_farm;
  assign phase_start = r_phase_start;
  assign state_o     = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus randomized traffic against
// an elapsed-tick reference model of the phase rules.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int unsigned T_HG_MIN = 4;
  localparam int unsigned T_Y      = 2;
  localparam int unsigned T_FG_MAX = 3;
  localparam int unsigned T_AR     = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_en = 1'b0;
  logic       car = 1'b0;
  logic [1:0] hwy_light;
  logic [1:0] farm_light;
  logic       phase_start;
  logic [2:0] state_o;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: phase name plus ticks spent in it.
  state_e m_state = HG;
  int     m_el    = 0;
  logic   m_ps    = 1'b0;
  logic   m_from_fy = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .CNT_W    (8),
    .T_HG_MIN (T_HG_MIN),
    .T_Y      (T_Y),
`ifdef ALL_RED_EN
    .T_FG_MAX (T_FG_MAX),
    .T_AR     (T_AR)
`else
    .T_FG_MAX (T_FG_MAX)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .car         (car),
    .hwy_light   (hwy_light),
    .farm_light  (farm_light),
    .phase_start (phase_start),
    .state_o     (state_o)
  );

  function automatic logic [3:0] m_lights(state_e s);
    case (s)
      HG:      return 4'b10_00;
      HY:      return 4'b01_00;
      FG:      return 4'b00_10;
      FY:      return 4'b00_01;
      default: return 4'b00_00;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic t, input logic c);
    logic   leave;
    state_e nxt;
    leave = 1'b0;
    nxt   = m_state;
    m_ps  = 1'b0;
    if (!r) begin
      m_state   = HG;
      m_el      = 0;
      m_from_fy = 1'b0;
    end else if (t) begin
      m_el = m_el + 1;
      case (m_state)
        HG: begin leave = (m_el >= int'(T_HG_MIN)) && c; nxt = HY; end
`ifdef ALL_RED_EN
        HY: begin leave = (m_el >= int'(T_Y)); nxt = AR; m_from_fy = 1'b0; end
        FG: begin leave = (m_el >= int'(T_FG_MAX)) || !c; nxt = FY; end
        FY: begin leave = (m_el >= int'(T_Y)); nxt = AR; m_from_fy = 1'b1; end
        AR: begin leave = (m_el >= int'(T_AR)); nxt = m_from_fy ? HG : FG; end
`else
        HY: begin leave = (m_el >= int'(T_Y)); nxt = FG; end
        FG: begin leave = (m_el >= int'(T_FG_MAX)) || !c; nxt = FY; end
        FY: begin leave = (m_el >= int'(T_Y)); nxt = HG; end
`endif
        default: begin leave = 1'b1; nxt = HG; end
      endcase
      if (leave) begin
        m_state = nxt;
        m_el    = 0;
        m_ps    = 1'b1;
      end
    end
  endtask

  // Drive one clock's worth of inputs, let the edge happen, update the model, sample after the edge.
  task automatic step(input logic r, input logic t, input logic c);
    rst_n   = r;
    tick_en = t;
    car     = c;
    @(posedge clk);
    model_edge(r, t, c);
    #1;
  endtask

  task automatic check_model(input string name);
    n_total++;
    if ({hwy_light, farm_light, phase_start, state_o} !==
        {m_lights(m_state), m_ps, 3'(m_state)}) begin
      $display("FAIL %s t=%0t: hwy/farm/ps/state got %b/%b/%b/%0d want %b/%b/%b/%0d", name, $time,
               hwy_light, farm_light, phase_start, state_o,
               m_lights(m_state) >> 2, m_lights(m_state) & 4'h3, m_ps, m_state);
    end else n_pass++;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if ({hwy_light, farm_light, phase_start, state_o} !== {2'b10, 2'b00, 1'b0, 3'(HG)}) begin
      $display("FAIL reset: got %b %b %b %0d want 10 00 0 %0d", hwy_light, farm_light,
               phase_start, state_o, HG);
    end else n_pass++;
  endtask

  task automatic test_idle_no_car();
    int bad = 0;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (hwy_light !== 2'b10 || farm_light !== 2'b00 || phase_start !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_hold: %0d bad cycles, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_car_fixed();
    logic exp_ps;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b1);
`ifdef ALL_RED_EN
      exp_ps = (i inside {4, 6, 7, 10, 12, 13});
`else
      exp_ps = (i inside {4, 6, 9, 11, 15});
`endif
      n_total++;
      if (phase_start !== exp_ps)
        $display("FAIL car_fixed_ps cycle %0d: got %b want %b", i, phase_start, exp_ps);
      else n_pass++;
      check_model("car_fixed_model");
    end
  endtask

  task automatic test_fg_early_exit();
    int   guard = 0;
    int   fg_len = 0;
    logic c = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    while (state_o !== 3'(FG) && guard < 50) begin
      step(1'b1, 1'b1, 1'b1);
      guard++;
    end
    n_total++;
    if (guard >= 50) $display("FAIL fg_reach: FG not reached in %0d cycles", guard);
    else n_pass++;
    fg_len = 1;
    c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, c);
      check_model("fg_early_model");
      if (state_o === 3'(FG) && i == fg_len - 1) fg_len++;
    end
    n_total++;
    if (fg_len != 1) $display("FAIL fg_early_len: got %0d cycles want 1", fg_len);
    else n_pass++;
  endtask

  task automatic test_slow_tick();
    int hg_len = 1;
    int hy_len = 0;
    logic in_hg = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 80; k++) begin
      step(1'b1, (k % 4) == 3, 1'b1);
      check_model("slow_tick_model");
      if (in_hg && state_o === 3'(HG)) hg_len++;
      else in_hg = 1'b0;
      if (state_o === 3'(HY) && !in_hg && k < 30) hy_len++;
    end
    n_total++;
    if (hg_len != 16) $display("FAIL slow_hg_len: got %0d clocks want 16", hg_len);
    else n_pass++;
    n_total++;
    if (hy_len != 8) $display("FAIL slow_hy_len: got %0d clocks want 8", hy_len);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    int hg_len = 1;
    step(1'b0, 1'b0, 1'b0);
    while (state_o !== 3'(FG) && guard < 50) begin
      step(1'b1, 1'b1, 1'b1);
      guard++;
    end
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if ({hwy_light, farm_light, state_o} !== {2'b10, 2'b00, 3'(HG)} || guard >= 50)
      $display("FAIL mid_reset: got %b %b %0d want 10 00 %0d (guard %0d)",
               hwy_light, farm_light, state_o, HG, guard);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check_model("mid_reset_model");
      if (state_o === 3'(HG) && hg_len == i + 1) hg_len++;
    end
    n_total++;
    if (hg_len != 4) $display("FAIL mid_reset_hg_len: got %0d want 4", hg_len);
    else n_pass++;
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      check_model("random_model");
    end
  endtask

  initial begin
    test_reset();
    test_idle_no_car();
    test_car_fixed();
    test_fg_early_exit();
    test_slow_tick();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
